// File: rtl/dsm_bitstream_decimator.sv
// rtl/dsm_bitstream_decimator.sv - sinc^2 CIC decimator reconstructing a DSM control word from its bitstream
// Optional over-range flag output enabled by DSM_DEC_OVERRANGE_EN.
module dsm_bitstream_decimator #(
  parameter int WIDTH = 16,
  parameter int LOG2R = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             settled
`ifdef DSM_DEC_OVERRANGE_EN
  ,
  output logic             sat_flag
`endif
);

  localparam int ACC   = 2*LOG2R + 1;
  localparam int SHIFT = 2*LOG2R - WIDTH;
  localparam logic [ACC-1:0] R_SQ = {1'b1, {(2*LOG2R){1'b0}}};

  logic [ACC-1:0]   i1_q, i1_d, i2_q, i2_d;
  logic [ACC-1:0]   i2h_q, i2h_d, c1h_q, c1h_d;
  logic [LOG2R-1:0] phase_q, phase_d;
  logic [1:0]       warm_q, warm_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             settled_q, settled_d;

  logic [ACC-1:0]   i1_sum, i2_sum, c1, raw;
  logic             tick, sat;
  logic [WIDTH-1:0] out_word;

`ifdef DSM_DEC_OVERRANGE_EN
  logic sat_q, sat_d, sat_seen_q, sat_seen_d;
`endif

  // Wrap-around in the integrators is harmless: the comb differences stay exact modulo 2^ACC.
  always_comb begin
    i1_sum   = i1_q + {{(ACC-1){1'b0}}, bit_in};
    i2_sum   = i2_q + i1_sum;
    c1       = i2_sum - i2h_q;
    raw      = c1 - c1h_q;
    tick     = en && (&phase_q);
    sat      = (raw == R_SQ);
    out_word = sat ? {WIDTH{1'b1}} : raw[SHIFT +: WIDTH];
  end

  always_comb begin
    i1_d      = i1_q;
    i2_d      = i2_q;
    i2h_d     = i2h_q;
    c1h_d     = c1h_q;
    phase_d   = phase_q;
    warm_d    = warm_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    settled_d = settled_q;
`ifdef DSM_DEC_OVERRANGE_EN
    sat_d      = sat_q;
    sat_seen_d = sat_seen_q;
`endif
    if (en) begin
      i1_d    = i1_sum;
      i2_d    = i2_sum;
      phase_d = phase_q + 1'b1;
    end
    if (tick) begin
      i2h_d = i2_sum;
      c1h_d = c1;
      if (warm_q != 2'd3) begin
        warm_d = warm_q + 2'd1;
      end
      // The first two ticks only prime the comb history.
      if (warm_q[1]) begin
        data_d    = out_word;
        valid_d   = 1'b1;
        settled_d = 1'b1;
`ifdef DSM_DEC_OVERRANGE_EN
        sat_d = sat;
        if (sat) begin
          sat_seen_d = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q      <= '0;
      i2_q      <= '0;
      i2h_q     <= '0;
      c1h_q     <= '0;
      phase_q   <= '0;
      warm_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      i2h_q     <= i2h_d;
      c1h_q     <= c1h_d;
      phase_q   <= phase_d;
      warm_q    <= warm_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      settled_q <= settled_d;
    end
  end

`ifdef DSM_DEC_OVERRANGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q      <= 1'b0;
      sat_seen_q <= 1'b0;
    end else begin
      sat_q      <= sat_d;
      sat_seen_q <= sat_seen_d;
    end
  end

  assign sat_flag = settled_q ? sat_q : sat_seen_q;
`endif

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign settled    = settled_q;

endmodule
